// File: rtl/uart_pkg.sv
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART types, default rates and baud divider helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_CLK_FREQ  = 100_000_000;
  localparam int DEFAULT_BAUD_RATE = 115_200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Clocks per bit; integer division truncates toward the faster rate.
  function automatic int baud_div(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
// Module : uart_tx_if
// Brief  : Byte request / busy handshake between a requester and uart_tx.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface uart_tx_if;

  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_start,
    output tx_data,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_data,
    output tx_busy,
    output tx_done
  );

endinterface

`default_nettype wire

// File: rtl/baud_counter.sv
// ============================================================================
// Module : baud_counter
// Brief  : Bit-period counter with clear; tick marks the last cycle of a bit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module baud_counter #(
  parameter int DIV = 868
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic en,
  input  wire logic clr,
  output logic      tick
);

  localparam int                CNT_W  = $clog2(DIV);
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en & (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : 8N1 UART transmitter, one frame per rising edge of a held start.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
  parameter int BAUD_RATE = DEFAULT_BAUD_RATE
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  uart_tx_if.slave   bus,
  output logic       tx
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD_RATE);

  tx_state_t  r_state;
  tx_state_t  w_state_nxt;
  logic       r_start_d;
  logic [7:0] r_shift;
  logic [2:0] r_bit_idx;
  logic       r_tx;
  logic       r_busy;
  logic       r_done;

  logic [7:0] w_shift_nxt;
  logic [2:0] w_bit_idx_nxt;
  logic       w_tx_nxt;
  logic       w_busy_nxt;
  logic       w_done_nxt;
  logic       w_clr;
  logic       w_tick;
  logic       w_start_rise;

  assign w_start_rise = bus.tx_start & ~r_start_d;

  baud_counter #(
    .DIV (BAUD_DIV)
  ) u_baud_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (r_state != IDLE),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  // start_d resets high so a start already held at reset release is not an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_d <= 1'b1;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_start_d <= bus.tx_start;
      r_shift   <= w_shift_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_rise)                 w_state_nxt = START;
      START:   if (w_tick)                       w_state_nxt = DATA;
      DATA:    if (w_tick && r_bit_idx == 3'd7)  w_state_nxt = STOP;
      STOP:    if (w_tick)                       w_state_nxt = IDLE;
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_shift_nxt   = r_shift;
    w_bit_idx_nxt = r_bit_idx;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_clr         = 1'b0;
    case (r_state)
      IDLE: begin
        w_tx_nxt = 1'b1;
        if (w_start_rise) begin
          w_shift_nxt = bus.tx_data;
          w_busy_nxt  = 1'b1;
          w_tx_nxt    = 1'b0;
          w_clr       = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_tx_nxt      = r_shift[0];
          w_bit_idx_nxt = 3'd0;
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_bit_idx != 3'd7) begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_tx_nxt      = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end else begin
            w_tx_nxt = 1'b1;
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_busy_nxt = 1'b0;
          w_done_nxt = 1'b1;
        end
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  assign tx          = r_tx;
  assign bus.tx_busy = r_busy;
  assign bus.tx_done = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module : tb_uart_tx
// Brief  : Directed frame vectors plus reset / retrigger corner sequences.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;

  uart_tx_if u_if ();

  uart_tx #(
    .CLK_FREQ  (80),
    .BAUD_RATE (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if.slave),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // exp[k] is the line level of bit slot k: 0 = start, 1..8 = data LSB first, 9 = stop.
  // mode: 0 plain, 1 data changes mid-frame, 2 start re-pulsed mid-frame, 3 start left high.
  typedef struct {
    logic [7:0] data;
    logic [9:0] exp;
    int         mode;
    string      name;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [9:0] exp, input int mode,
                            input string name);
    logic [79:0] smp;
    int          busy_cnt;
    int          done_cnt;
    bit          seen;
    @(negedge clk);
    u_if.tx_data  = d;
    u_if.tx_start = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      if (u_if.tx_busy === 1'b1) seen = 1'b1;
    end
    check($sformatf("%s accept", name), 32'(seen), 32'd1);
    if (!seen) begin
      u_if.tx_start = 1'b0;
      return;
    end
    busy_cnt = 0;
    done_cnt = 0;
    smp      = '0;
    for (int c = 0; c < 80; c++) begin
      if (c > 0) @(negedge clk);
      smp[c] = tx;
      if (u_if.tx_busy === 1'b1) busy_cnt++;
      if (u_if.tx_done === 1'b1) done_cnt++;
      if (mode == 1 && c == 20) u_if.tx_data  = 8'h00;
      if (mode == 2 && c == 29) u_if.tx_start = 1'b0;
      if (mode == 2 && c == 30) u_if.tx_start = 1'b1;
    end
    for (int s = 0; s < 10; s++) begin
      check($sformatf("%s slot%0d", name, s), 32'(smp[s*8 +: 8]), exp[s] ? 32'hFF : 32'h00);
    end
    check($sformatf("%s busy_cycles", name), 32'(busy_cnt), 32'd80);
    check($sformatf("%s early_done", name), 32'(done_cnt), 32'd0);
    @(negedge clk);
    check($sformatf("%s end busy/done/tx", name),
          32'({u_if.tx_busy, u_if.tx_done, tx}), 32'b011);
    @(negedge clk);
    check($sformatf("%s post busy/done/tx", name),
          32'({u_if.tx_busy, u_if.tx_done, tx}), 32'b001);
    if (mode != 3) begin
      u_if.tx_start = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  viol;
    bit  seen;

    vecs[0] = '{8'h55, 10'h2AA, 0, "h55"};
    vecs[1] = '{8'h33, 10'h266, 0, "disp_3"};
    vecs[2] = '{8'h78, 10'h2F0, 0, "disp_x"};
    vecs[3] = '{8'h34, 10'h268, 0, "disp_4"};
    vecs[4] = '{8'hA5, 10'h34A, 1, "data_change"};
    vecs[5] = '{8'hFF, 10'h3FE, 2, "start_repulse"};
    vecs[6] = '{8'h00, 10'h200, 0, "h00"};
    vecs[7] = '{8'h0F, 10'h21E, 3, "hold_start"};

    u_if.tx_start = 1'b0;
    u_if.tx_data  = 8'h00;
    rst_n         = 1'b0;
    #12;
    check("reset busy/done/tx", 32'({u_if.tx_busy, u_if.tx_done, tx}), 32'b001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      send_frame(vecs[i].data, vecs[i].exp, vecs[i].mode, vecs[i].name);
    end

    // tx_start is still high from the last vector: no frame may follow.
    viol = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || u_if.tx_busy !== 1'b0) viol++;
    end
    check("held start no retrigger", 32'(viol), 32'd0);
    u_if.tx_start = 1'b0;
    @(negedge clk);

    // Reset asserted at cycle 40 of a frame, while the line is low.
    u_if.tx_data  = 8'h00;
    u_if.tx_start = 1'b1;
    seen = 1'b0;
    for (int w = 0; w < 4 && !seen; w++) begin
      @(negedge clk);
      if (u_if.tx_busy === 1'b1) seen = 1'b1;
    end
    check("rst frame accept", 32'(seen), 32'd1);
    for (int c = 0; c < 40; c++) @(negedge clk);
    check("rst frame line low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("async reset busy/tx", 32'({u_if.tx_busy, tx}), 32'b01);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    viol = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (tx !== 1'b1 || u_if.tx_busy !== 1'b0) viol++;
    end
    check("start held at reset release", 32'(viol), 32'd0);
    u_if.tx_start = 1'b0;
    @(negedge clk);
    send_frame(8'h3C, 10'h278, 0, "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
